imem_boot_sequencer: RTL and testbench

Boot and run sequencer for the single-cycle MIPS core. Holds the processor in reset, streams program words into instruction memory over a valid/ready port, releases the processor for a programmed number of cycles, then re-asserts reset and reports completion. It sits between the host/loader and the core's reset pin and instruction-memory write port, and replaces ad-hoc memory preloading.

---
 rtl/mips_boot_pkg.sv | 22 ++
 rtl/boot_checksum.sv | 36 +++
 rtl/imem_boot_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and default widths for the MIPS instruction-memory boot sequencer.
// The CHECK/ERROR states are only reachable when BOOT_CHECKSUM_EN is defined.
package mips_boot_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int RUN_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } boot_state_e;

  function automatic logic state_is_busy(input boot_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/boot_checksum.sv
// Running modulo-2^DATA_W sum of loaded program words, compared against a trailer word.
// Only instantiated by imem_boot_sequencer when BOOT_CHECKSUM_EN is defined.
module boot_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accumulate,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] compare_in,
  output logic              match
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (accumulate) begin
      sum_d = sum_q + data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == compare_in);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Holds the core in reset, streams words into instruction memory, runs the core for a
// cycle budget, then reports done. Optional trailer checksum via BOOT_CHECKSUM_EN.
module imem_boot_sequencer
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RUN_W  = RUN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE_IDX   = 1;
  localparam logic [RUN_W-1:0] ONE_CYC   = 1;
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_LOAD = ST_CHECK;
`else
  localparam boot_state_e AFTER_LOAD = ST_RUN;
`endif

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [RUN_W-1:0]  budget_q, budget_d;
  logic [RUN_W-1:0]  cyc_q, cyc_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   wc_clamped;
  logic              accept;
  logic              last_word;

`ifdef BOOT_CHECKSUM_EN
  logic error_q, error_d;
  logic sum_clear, sum_acc, sum_match;

  boot_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk        (clk),
    .reset      (reset),
    .clear      (sum_clear),
    .accumulate (sum_acc),
    .data_in    (s_data),
    .compare_in (s_data),
    .match      (sum_match)
  );
`endif

  assign wc_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign s_ready    = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  // abort wins over a same-cycle transfer, so the word is dropped rather than written
  assign accept     = s_valid && s_ready && !abort;
  assign last_word  = ((idx_q + ONE_IDX) == len_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    budget_d   = budget_q;
    cyc_d      = '0;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_clear  = 1'b0;
    sum_acc    = 1'b0;
`endif

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            len_d    = wc_clamped;
            budget_d = run_cycles;
            idx_d    = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_clear = 1'b1;
`endif
            state_d  = (wc_clamped == '0) ? AFTER_LOAD : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            im_we_d    = 1'b1;
            im_addr_d  = idx_q[ADDR_W-1:0];
            im_wdata_d = s_data;
            idx_d      = idx_q + ONE_IDX;
`ifdef BOOT_CHECKSUM_EN
            sum_acc    = 1'b1;
`endif
            if (last_word) begin
              state_d = AFTER_LOAD;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            state_d = sum_match ? ST_RUN : ST_ERROR;
          end
        end
`endif
        ST_RUN: begin
          // a zero budget never matches, leaving the core running until abort
          cyc_d = cyc_q + ONE_CYC;
          if ((budget_q != '0) && (cyc_q == (budget_q - ONE_CYC))) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // status outputs are registered from the next state so they change on the entering edge
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_DONE);
`ifdef BOOT_CHECKSUM_EN
    error_d     = (state_d == ST_ERROR);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      budget_q    <= '0;
      cyc_q       <= '0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      budget_q    <= budget_d;
      cyc_q       <= cyc_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
`ifdef BOOT_CHECKSUM_EN
      error_q     <= error_d;
`endif
    end
  end

  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = state_is_busy(state_q);
  assign done      = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer: a write scoreboard plus cycle counting of the
// core's reset-low window. Define BOOT_CHECKSUM_EN to exercise the trailer checksum path.
module tb_imem_boot_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW:0]   word_count;
  logic [RW-1:0] run_cycles;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  int vectors     = 0;
  int miscompares = 0;
  bit scoreOn     = 1'b0;

  // expected memory writes, {address, data}, in the order the stream delivers them
  logic [AW+DW-1:0] expQ[$];

  imem_boot_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RUN_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .run_cycles (run_cycles),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // every write the DUT issues must be the next word the bench handed over
  always @(negedge clk) begin
    logic [AW+DW-1:0] expWord;
    if (scoreOn && reset && im_we) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", im_addr, im_wdata);
      end else begin
        expWord = expQ.pop_front();
        if ({im_addr, im_wdata} !== expWord) begin
          miscompares++;
          $display("[TB] FAIL write_content: got addr %0h data %0h, expected addr %0h data %0h",
                   im_addr, im_wdata, expWord[AW+DW-1:DW], expWord[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wordVal(input int seed, input int i);
    return 32'hA500_0000 ^ DW'(seed << 12) ^ DW'(i * 3 + 1);
  endfunction

  task automatic applyStimulus(input logic [AW:0] wc, input logic [RW-1:0] rc);
    start      = 1'b1;
    word_count = wc;
    run_cycles = rc;
    tick();
    start = 1'b0;
  endtask

  // n words, optionally with an idle cycle before each word after the first
  task automatic sendWords(input int n, input bit gaps, input int seed);
    logic [DW-1:0] sum;
    logic [DW-1:0] w;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
        tick();
      end
      w       = wordVal(seed, i);
      s_valid = 1'b1;
      s_data  = w;
      expQ.push_back({i[AW-1:0], w});
      sum     = sum + w;
      tick();
    end
`ifdef BOOT_CHECKSUM_EN
    s_valid = 1'b1;
    s_data  = sum;
    tick();
`endif
    s_valid = 1'b0;
  endtask

  task automatic countRun(input int budget, output int lowCycles, output bit sawDone);
    lowCycles = 0;
    sawDone   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (!cpu_reset) lowCycles++;
      tick();
    end
  endtask

  task automatic runAndCheck(input string name, input int rc);
    int lowCycles;
    bit sawDone;
    countRun(rc + 20, lowCycles, sawDone);
    checkOutput({name, "_done_seen"}, sawDone, 1'b1);
    checkOutput({name, "_reset_low_cycles"}, lowCycles, rc);
    checkOutput({name, "_cpu_reset_after"}, cpu_reset, 1'b1);
    checkOutput({name, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int lowCycles;
    bit sawDone;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    word_count = '0; run_cycles = '0; s_valid = 1'b0; s_data = '0;
    #23;
    checkOutput("reset_cpu_reset", cpu_reset, 1'b1);
    checkOutput("reset_outputs", {s_ready, im_we, busy, done, error}, 5'b0);
    reset = 1'b1;
    tick();
    scoreOn = 1'b1;

    $display("[TB] five back-to-back words, 10 run cycles");
    applyStimulus(9'd5, 16'd10);
    checkOutput("load_s_ready", s_ready, 1'b1);
    checkOutput("load_busy", busy, 1'b1);
    checkOutput("load_cpu_reset", cpu_reset, 1'b1);
    sendWords(5, 1'b0, 1);
    checkOutput("ready_drops_after_last", s_ready, 1'b0);
    checkOutput("cpu_reset_low_entering_run", cpu_reset, 1'b0);
    runAndCheck("run10", 10);
    checkOutput("done_held", done, 1'b1);
    tick(); tick();
    checkOutput("done_still_held", done, 1'b1);

    $display("[TB] toggling valid, three words");
    applyStimulus(9'd3, 16'd2);
    checkOutput("start_clears_done", done, 1'b0);
    sendWords(3, 1'b1, 2);
    runAndCheck("run2", 2);

    $display("[TB] single word, single run cycle");
    applyStimulus(9'd1, 16'd1);
    sendWords(1, 1'b0, 3);
    runAndCheck("run1", 1);

    $display("[TB] abort on third word");
    applyStimulus(9'd5, 16'd4);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = wordVal(4, i);
      expQ.push_back({i[AW-1:0], wordVal(4, i)});
      tick();
    end
    s_valid = 1'b1;
    s_data  = wordVal(4, 2);
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_cpu_reset", cpu_reset, 1'b1);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_s_ready", s_ready, 1'b0);
    tick(); tick(); tick();
    checkOutput("abort_no_progress", {busy, cpu_reset}, 2'b01);

    $display("[TB] zero words, unlimited run");
    applyStimulus(9'd0, 16'd0);
    sendWords(0, 1'b0, 5);
    checkOutput("unlimited_cpu_reset", cpu_reset, 1'b0);
    countRun(50, lowCycles, sawDone);
    checkOutput("unlimited_no_done", sawDone, 1'b0);
    checkOutput("unlimited_low_cycles", lowCycles, 50);
    start = 1'b1; word_count = 9'd3; run_cycles = 16'd1;
    tick();
    start = 1'b0;
    checkOutput("start_ignored_busy", {busy, cpu_reset, s_ready}, 3'b100);
    s_valid = 1'b1; s_data = 32'h1234_5678;
    tick(); tick(); tick();
    checkOutput("valid_ignored_in_run", s_ready, 1'b0);
    s_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("unlimited_abort", {busy, cpu_reset, done}, 3'b010);

    $display("[TB] word_count clamped to full memory");
    applyStimulus(9'h1FF, 16'd3);
    sendWords(256, 1'b0, 6);
    checkOutput("clamp_entered_run", cpu_reset, 1'b0);
    runAndCheck("clamp_run3", 3);

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] checksum trailer good then bad");
    applyStimulus(9'd3, 16'd5);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i + 1);
      expQ.push_back({i[AW-1:0], DW'(i + 1)});
      tick();
    end
    s_data = 32'd6;
    tick();
    s_valid = 1'b0;
    checkOutput("csum_good_runs", {cpu_reset, error}, 2'b00);
    abort = 1'b1; tick(); abort = 1'b0;
    applyStimulus(9'd3, 16'd5);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i + 1);
      expQ.push_back({i[AW-1:0], DW'(i + 1)});
      tick();
    end
    s_data = 32'd7;
    tick();
    s_valid = 1'b0;
    checkOutput("csum_bad_error", {error, cpu_reset, busy}, 3'b110);
    tick(); tick();
    checkOutput("csum_bad_held", {error, cpu_reset}, 2'b11);
    abort = 1'b1; tick(); abort = 1'b0;
    checkOutput("csum_abort_clears", error, 1'b0);
`else
    checkOutput("error_tied_low", error, 1'b0);
`endif

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(9'd2, 16'd0);
    sendWords(2, 1'b0, 7);
    tick(); tick();
    checkOutput("pre_reset_running", cpu_reset, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_cpu_reset", cpu_reset, 1'b1);
    checkOutput("async_reset_flags", {s_ready, im_we, busy, done, error}, 5'b0);
    checkOutput("async_reset_addr", im_addr, 8'h00);
    checkOutput("async_reset_wdata", im_wdata, 32'h0);
    #3;
    reset = 1'b1;
    tick();
    checkOutput("post_reset_idle", {busy, cpu_reset}, 2'b01);

    checkOutput("all_expected_writes_seen", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
